// File: rtl/uart_rx_flow_ctrl.sv
// UART receive-side FIFO with RTS watermark flow control and sticky error status.
// Define UART_RX_ERR_COUNT_EN to add the saturating Err_Count output.
module uart_rx_flow_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int HIGH_WATER = 6,
  parameter int LOW_WATER  = 2
) (
  input  logic                            Clk,
  input  logic                            Rst_N,
  input  logic [DATA_BITS-1:0]            Rx_Data_In,
  input  logic                            Rx_Data_Rdy_In,
  input  logic [2:0]                      Rx_Error_In,
  output logic                            RTS_Out,
  output logic                            Rd_Valid,
  output logic [DATA_BITS-1:0]            Rd_Data,
  input  logic                            Rd_En,
  output logic [$clog2(FIFO_DEPTH):0]     Fifo_Count,
  output logic [3:0]                      Err_Status,
`ifdef UART_RX_ERR_COUNT_EN
  output logic [7:0]                      Err_Count,
`endif
  input  logic                            Err_Clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HW_C    = CW'(HIGH_WATER);
  localparam logic [CW-1:0] LW_C    = CW'(LOW_WATER);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    status_q, status_d;
  logic          rdy_q, err_q;
  logic          rts_q, rts_d;

  logic good_evt, err_evt;
  logic full, empty;
  logic pop, do_push, ovr;

  // Level inputs count once: only the rising edge is an event.
  assign good_evt = Rx_Data_Rdy_In & ~rdy_q;
  assign err_evt  = (|Rx_Error_In) & ~err_q;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign pop     = Rd_En & ~empty;
  assign do_push = good_evt & (~full | pop);
  assign ovr     = good_evt & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(pop);
  end

  always_comb begin
    status_d = Err_Clr ? 4'b0000 : status_q;
    if (err_evt) status_d[2:0] = status_d[2:0] | Rx_Error_In;
    if (ovr)     status_d[3]   = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  if (count_d >= HW_C) state_d = ST_HOLD;
      ST_HOLD: if (count_d <= LW_C) state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
    rts_d = (state_d == ST_RUN);
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q  <= ST_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      rts_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
      rdy_q    <= Rx_Data_Rdy_In;
      err_q    <= |Rx_Error_In;
      rts_q    <= rts_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= Rx_Data_In;
  end

  // Empty FIFO presents zero so stale entries never leak to the host.
  assign Rd_Data    = empty ? '0 : mem_q[rd_ptr_q];
  assign Rd_Valid   = ~empty;
  assign Fifo_Count = count_q;
  assign Err_Status = status_q;
  assign RTS_Out    = rts_q;

`ifdef UART_RX_ERR_COUNT_EN
  logic [7:0] ecnt_q, ecnt_d;
  logic [1:0] n_evt;
  logic [8:0] sum;

  assign n_evt = {1'b0, err_evt} + {1'b0, ovr};
  assign sum   = {1'b0, ecnt_q} + {7'd0, n_evt};

  always_comb begin
    ecnt_d = ecnt_q;
    if (Err_Clr)       ecnt_d = {6'd0, n_evt};
    else if (sum[8])   ecnt_d = 8'hFF;
    else               ecnt_d = sum[7:0];
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) ecnt_q <= '0;
    else        ecnt_q <= ecnt_d;
  end

  assign Err_Count = ecnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_flow_ctrl.sv
// Directed self-checking bench for uart_rx_flow_ctrl.
// Build with +define+UART_RX_ERR_COUNT_EN to also cover Err_Count.
`timescale 1ns/1ps
module tb_uart_rx_flow_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_N;
  logic [7:0] Rx_Data_In;
  logic       Rx_Data_Rdy_In;
  logic [2:0] Rx_Error_In;
  logic       RTS_Out;
  logic       Rd_Valid;
  logic [7:0] Rd_Data;
  logic       Rd_En;
  logic [3:0] Fifo_Count;
  logic [3:0] Err_Status;
  logic       Err_Clr;
`ifdef UART_RX_ERR_COUNT_EN
  logic [7:0] Err_Count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  uart_rx_flow_ctrl dut (
    .Clk            (Clk),
    .Rst_N          (Rst_N),
    .Rx_Data_In     (Rx_Data_In),
    .Rx_Data_Rdy_In (Rx_Data_Rdy_In),
    .Rx_Error_In    (Rx_Error_In),
    .RTS_Out        (RTS_Out),
    .Rd_Valid       (Rd_Valid),
    .Rd_Data        (Rd_Data),
    .Rd_En          (Rd_En),
    .Fifo_Count     (Fifo_Count),
    .Err_Status     (Err_Status),
`ifdef UART_RX_ERR_COUNT_EN
    .Err_Count      (Err_Count),
`endif
    .Err_Clr        (Err_Clr)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] d);
    Rx_Data_In = d;
    Rx_Data_Rdy_In = 1'b1;
    tick();
    Rx_Data_Rdy_In = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    total++;
    if (Fifo_Count !== 4'd0 || Rd_Valid !== 1'b0 || Rd_Data !== 8'h00 ||
        Err_Status !== 4'h0 || RTS_Out !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals cnt=%0d vld=%b dat=%h st=%b rts=%b exp 0/0/00/0000/0",
               Fifo_Count, Rd_Valid, Rd_Data, Err_Status, RTS_Out);
    end
    Rst_N = 1'b1;
    tick();
    total++;
    if (RTS_Out !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_rts got=%b exp=1", RTS_Out);
    end
  endtask

  task automatic test_basic_push();
    Rx_Data_In = 8'hA5;
    Rx_Data_Rdy_In = 1'b1;
    tick();
    total++;
    if (Rd_Valid !== 1'b1 || Rd_Data !== 8'hA5 || Fifo_Count !== 4'd1) begin
      bad++;
      $display("FAIL first_push vld=%b dat=%h cnt=%0d exp 1/a5/1",
               Rd_Valid, Rd_Data, Fifo_Count);
    end
    Rx_Data_Rdy_In = 1'b0;
    tick();
    push_frame(8'h3C);
    total++;
    if (Rd_Data !== 8'hA5 || Fifo_Count !== 4'd2 || RTS_Out !== 1'b1) begin
      bad++;
      $display("FAIL two_push dat=%h cnt=%0d rts=%b exp a5/2/1",
               Rd_Data, Fifo_Count, RTS_Out);
    end
    Rd_En = 1'b1;
    tick();
    total++;
    if (Rd_Data !== 8'h3C || Fifo_Count !== 4'd1) begin
      bad++;
      $display("FAIL pop_one dat=%h cnt=%0d exp 3c/1", Rd_Data, Fifo_Count);
    end
    tick();
    Rd_En = 1'b0;
    total++;
    if (Rd_Valid !== 1'b0 || Fifo_Count !== 4'd0 || Rd_Data !== 8'h00) begin
      bad++;
      $display("FAIL pop_empty vld=%b cnt=%0d dat=%h exp 0/0/00",
               Rd_Valid, Fifo_Count, Rd_Data);
    end
  endtask

  task automatic test_watermark();
    for (int i = 0; i < 5; i++) push_frame(8'h10 + 8'(i));
    total++;
    if (Fifo_Count !== 4'd5 || RTS_Out !== 1'b1) begin
      bad++;
      $display("FAIL wm_five cnt=%0d rts=%b exp 5/1", Fifo_Count, RTS_Out);
    end
    Rx_Data_In = 8'h15;
    Rx_Data_Rdy_In = 1'b1;
    tick();
    Rx_Data_Rdy_In = 1'b0;
    total++;
    if (Fifo_Count !== 4'd6 || RTS_Out !== 1'b0) begin
      bad++;
      $display("FAIL wm_high cnt=%0d rts=%b exp 6/0", Fifo_Count, RTS_Out);
    end
    tick();
    Rd_En = 1'b1;
    tick(); tick(); tick();
    total++;
    if (Fifo_Count !== 4'd3 || RTS_Out !== 1'b0 || Rd_Data !== 8'h13) begin
      bad++;
      $display("FAIL wm_three cnt=%0d rts=%b dat=%h exp 3/0/13",
               Fifo_Count, RTS_Out, Rd_Data);
    end
    tick();
    total++;
    if (Fifo_Count !== 4'd2 || RTS_Out !== 1'b1 || Rd_Data !== 8'h14) begin
      bad++;
      $display("FAIL wm_low cnt=%0d rts=%b dat=%h exp 2/1/14",
               Fifo_Count, RTS_Out, Rd_Data);
    end
    tick(); tick();
    Rd_En = 1'b0;
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) push_frame(8'h20 + 8'(i));
    total++;
    if (Fifo_Count !== 4'd8 || RTS_Out !== 1'b0) begin
      bad++;
      $display("FAIL full_fill cnt=%0d rts=%b exp 8/0", Fifo_Count, RTS_Out);
    end
    Rx_Data_In = 8'hFF;
    Rx_Data_Rdy_In = 1'b1;
    tick();
    Rx_Data_Rdy_In = 1'b0;
    total++;
    if (Err_Status !== 4'b1000 || Fifo_Count !== 4'd8 || Rd_Data !== 8'h20) begin
      bad++;
      $display("FAIL overrun st=%b cnt=%0d dat=%h exp 1000/8/20",
               Err_Status, Fifo_Count, Rd_Data);
    end
    Err_Clr = 1'b1;
    tick();
    Err_Clr = 1'b0;
    Rx_Data_Rdy_In = 1'b1;
    Rd_En = 1'b1;
    tick();
    Rx_Data_Rdy_In = 1'b0;
    Rd_En = 1'b0;
    total++;
    if (Err_Status !== 4'b0000 || Fifo_Count !== 4'd8 || Rd_Data !== 8'h21) begin
      bad++;
      $display("FAIL full_push_pop st=%b cnt=%0d dat=%h exp 0000/8/21",
               Err_Status, Fifo_Count, Rd_Data);
    end
    tick();
    Rd_En = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 7) ? 8'h21 + 8'(i) : 8'hFF;
      total++;
      if (Rd_Data !== exp_d) begin
        bad++;
        $display("FAIL drain_%0d got=%h exp=%h", i, Rd_Data, exp_d);
      end
      tick();
    end
    Rd_En = 1'b0;
    total++;
    if (Fifo_Count !== 4'd0 || RTS_Out !== 1'b1) begin
      bad++;
      $display("FAIL drained cnt=%0d rts=%b exp 0/1", Fifo_Count, RTS_Out);
    end
  endtask

  task automatic test_errors();
    Rx_Error_In = 3'b110;
    tick();
    Rx_Error_In = 3'b000;
    total++;
    if (Err_Status !== 4'b0110 || Fifo_Count !== 4'd0) begin
      bad++;
      $display("FAIL err_latch st=%b cnt=%0d exp 0110/0", Err_Status, Fifo_Count);
    end
    tick();
    Err_Clr = 1'b1;
    tick();
    Err_Clr = 1'b0;
    total++;
    if (Err_Status !== 4'b0000) begin
      bad++;
      $display("FAIL err_clr got=%b exp=0000", Err_Status);
    end
    Err_Clr = 1'b1;
    Rx_Error_In = 3'b001;
    tick();
    Err_Clr = 1'b0;
    Rx_Error_In = 3'b000;
    total++;
    if (Err_Status !== 4'b0001) begin
      bad++;
      $display("FAIL err_clr_wins got=%b exp=0001", Err_Status);
    end
    tick();
    Rx_Data_In = 8'h5A;
    Rx_Data_Rdy_In = 1'b1;
    Rx_Error_In = 3'b010;
    tick();
    Rx_Data_Rdy_In = 1'b0;
    Rx_Error_In = 3'b000;
    total++;
    if (Err_Status !== 4'b0011 || Fifo_Count !== 4'd1 || Rd_Data !== 8'h5A) begin
      bad++;
      $display("FAIL good_and_err st=%b cnt=%0d dat=%h exp 0011/1/5a",
               Err_Status, Fifo_Count, Rd_Data);
    end
    Rd_En = 1'b1;
    Err_Clr = 1'b1;
    tick();
    Rd_En = 1'b0;
    Err_Clr = 1'b0;
  endtask

  task automatic test_held_strobe();
    Rx_Data_In = 8'h77;
    Rx_Data_Rdy_In = 1'b1;
    tick(); tick(); tick();
    Rx_Data_Rdy_In = 1'b0;
    total++;
    if (Fifo_Count !== 4'd1) begin
      bad++;
      $display("FAIL held_strobe cnt=%0d exp=1", Fifo_Count);
    end
    tick();
    Rd_En = 1'b1;
    tick(); tick(); tick();
    Rd_En = 1'b0;
    total++;
    if (Fifo_Count !== 4'd0 || Rd_Valid !== 1'b0) begin
      bad++;
      $display("FAIL underflow cnt=%0d vld=%b exp 0/0", Fifo_Count, Rd_Valid);
    end
  endtask

`ifdef UART_RX_ERR_COUNT_EN
  task automatic test_err_count();
    Err_Clr = 1'b1;
    tick();
    Err_Clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      Rx_Error_In = 3'b001;
      tick();
      Rx_Error_In = 3'b000;
      tick();
    end
    total++;
    if (Err_Count !== 8'd255) begin
      bad++;
      $display("FAIL errcnt_sat got=%0d exp=255", Err_Count);
    end
    Err_Clr = 1'b1;
    tick();
    total++;
    if (Err_Count !== 8'd0) begin
      bad++;
      $display("FAIL errcnt_clr got=%0d exp=0", Err_Count);
    end
    Rx_Error_In = 3'b100;
    tick();
    Err_Clr = 1'b0;
    Rx_Error_In = 3'b000;
    total++;
    if (Err_Count !== 8'd1) begin
      bad++;
      $display("FAIL errcnt_clr_evt got=%0d exp=1", Err_Count);
    end
    Err_Clr = 1'b1;
    tick();
    Err_Clr = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    push_frame(8'h01);
    push_frame(8'h02);
    push_frame(8'h03);
    Rx_Error_In = 3'b100;
    tick();
    Rx_Error_In = 3'b000;
    #2 Rst_N = 1'b0;
    #1;
    total++;
    if (Fifo_Count !== 4'd0 || Rd_Valid !== 1'b0 || Rd_Data !== 8'h00 ||
        Err_Status !== 4'h0 || RTS_Out !== 1'b0) begin
      bad++;
      $display("FAIL async_reset cnt=%0d vld=%b dat=%h st=%b rts=%b exp 0/0/00/0000/0",
               Fifo_Count, Rd_Valid, Rd_Data, Err_Status, RTS_Out);
    end
`ifdef UART_RX_ERR_COUNT_EN
    total++;
    if (Err_Count !== 8'd0) begin
      bad++;
      $display("FAIL async_reset_errcnt got=%0d exp=0", Err_Count);
    end
`endif
    tick(); tick();
    Rst_N = 1'b1;
    tick();
    total++;
    if (RTS_Out !== 1'b1 || Fifo_Count !== 4'd0) begin
      bad++;
      $display("FAIL post_reset rts=%b cnt=%0d exp 1/0", RTS_Out, Fifo_Count);
    end
  endtask

  initial begin
    Rst_N = 1'b0;
    Rx_Data_In = '0;
    Rx_Data_Rdy_In = 1'b0;
    Rx_Error_In = '0;
    Rd_En = 1'b0;
    Err_Clr = 1'b0;
    tick();
    tick();
    test_reset();
    test_basic_push();
    test_watermark();
    test_overrun();
    test_errors();
    test_held_strobe();
`ifdef UART_RX_ERR_COUNT_EN
    test_err_count();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
